// File: rtl/sft_reg_ctrl_if.sv
// Command/handshake bundle between the upstream command FSM, the
// shift-register sequencing controller and the shift-register datapath.
interface sft_reg_ctrl_if #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 4
);
  // Command side
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] data_in;
  logic             abort;

  // Status side
  logic             ready;
  logic             done;
  logic             aborted;

  // Datapath controls toward the shift register
  logic             ld_sft_reg;
  logic [1:0]       LR_sft_en;
  logic [WIDTH-1:0] sft_reg_in;

  // Upstream command source
  modport master (
    output start, dir, shift_cnt, data_in, abort,
    input  ready, done, aborted, ld_sft_reg, LR_sft_en, sft_reg_in
  );

  // Sequencing controller
  modport slave (
    input  start, dir, shift_cnt, data_in, abort,
    output ready, done, aborted, ld_sft_reg, LR_sft_en, sft_reg_in
  );
endinterface

// File: rtl/sft_reg_ctrl.sv
// Sequencing controller for the shift-register datapath: one load cycle,
// then N shift cycles (N clamped to WIDTH), then a one-cycle done pulse.
// Load and shift enables are decoded from mutually exclusive states, so
// they can never be asserted in the same cycle.
module sft_reg_ctrl #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 4   // 2**CNT_W must exceed WIDTH
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  sft_reg_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest shift count that still changes the result; anything above
  // empties the register anyway, so it is clamped to bound latency.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             ld_q, ld_d;
  logic [1:0]       lr_q, lr_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             accept;
  logic             cancel;

  // Abort only matters while a command is in flight; in IDLE it also
  // suppresses a simultaneous start.
  assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;
  assign cancel = (state_q != S_IDLE) && bus.abort;

  // State and registered-output flops, cleared asynchronously
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      data_q    <= '0;
      ld_q      <= 1'b0;
      lr_q      <= 2'b00;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      ld_q      <= ld_d;
      lr_q      <= lr_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state, command latching and remaining-count bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dir_d   = bus.dir;
          data_d  = bus.data_in;
          cnt_d   = (bus.shift_cnt > MAX_CNT) ? MAX_CNT : bus.shift_cnt;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (cnt_q != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        // Leave on the cycle the count reaches zero: N cycles in SHIFT.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Registered outputs decoded from the state being entered
  always_comb begin
    ld_d      = (state_d == S_LOAD);
    lr_d      = (state_d == S_SHIFT) ? {1'b1, dir_d} : 2'b00;
    done_d    = (state_d == S_DONE);
    aborted_d = cancel;
  end

  assign bus.ready      = (state_q == S_IDLE);
  assign bus.ld_sft_reg = ld_q;
  assign bus.LR_sft_en  = lr_q;
  assign bus.sft_reg_in = data_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_sft_reg_ctrl.sv
// Scoreboard bench for sft_reg_ctrl: the driver pushes the expected outcome
// of each accepted command; a negedge monitor pops it when done/aborted
// appears and checks latency, pulses and the resulting register value.
module tb_sft_reg_ctrl;
  localparam int W  = 9;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sft_reg_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  sft_reg_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    int           lat;       // cycles from first ld cycle to done/aborted
    logic         is_abort;
    logic [W-1:0] res;       // register value when done/aborted is seen
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   active = 0;
  int   cyc = 0;
  int   ld_cnt = 0;
  int   total_ld = 0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] sreg = '0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endfunction

  // Reference: N single-bit shifts with zero fill
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, logic dr, int n);
    if (n >= W) return '0;
    return dr ? (d >> n) : (d << n);
  endfunction

  // Shift register datapath model: shift has priority over load
  always @(posedge clk) begin
    if (bus.LR_sft_en[1]) sreg <= bus.LR_sft_en[0] ? (sreg >> 1) : (sreg << 1);
    else if (bus.ld_sft_reg) sreg <= bus.sft_reg_in;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.ld_sft_reg && bus.LR_sft_en[1]))
    else $error("FAIL ld_shift_overlap_assert");

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
      exp_q.delete();
    end else begin
      chk("ld_lr_overlap", 32'(bus.ld_sft_reg & bus.LR_sft_en[1]), 0);
      if (bus.ld_sft_reg) total_ld++;
      if (active) begin
        cyc++;
        if (bus.ld_sft_reg) ld_cnt++;
        if (bus.LR_sft_en[1]) chk("shift_dir", 32'(bus.LR_sft_en[0]), 32'(cur.dir));
        if (bus.done || bus.aborted) begin
          chk("end_kind", 32'(bus.aborted), 32'(cur.is_abort));
          chk("done_and_aborted", 32'(bus.done & bus.aborted), 0);
          chk("latency", 32'(cyc), 32'(cur.lat));
          chk("reg_result", 32'(sreg), 32'(cur.res));
          chk("ld_pulses", 32'(ld_cnt), 1);
          chk("ready_at_end", 32'(bus.ready), 32'(cur.is_abort));
          $display("cmd data=0x%03h dir=%0d abort=%0d lat=%0d reg=0x%03h", cur.data, cur.dir,
                   cur.is_abort, cyc, sreg);
          active = 0;
        end else begin
          chk("busy_ready", 32'(bus.ready), 0);
          if (cyc > 40) begin
            chk("cmd_timeout", 32'(cyc), 32'(cur.lat));
            active = 0;
          end
        end
      end else if (bus.ld_sft_reg) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ld", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          active = 1;
          cyc = 0;
          ld_cnt = 1;
          chk("load_data", 32'(bus.sft_reg_in), 32'(cur.data));
        end
      end else begin
        if (bus.done) chk("unexpected_done", 1, 0);
        if (bus.aborted) chk("unexpected_aborted", 1, 0);
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!bus.ready && g < 60) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.ready) chk("ready_timeout", 0, 1);
  endtask

  // Issue one command; abort_k>0 raises abort so it is sampled at edge E(k)
  task automatic issue(input logic [W-1:0] d, input logic dr, input int n,
                       input int abort_k, input bit hold);
    exp_t e;
    int   nc;
    wait_ready();
    nc = (n > W) ? W : n;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.data_in = d;
    bus.dir = dr;
    bus.shift_cnt = CW'(n);
    e.data = d;
    e.dir = dr;
    if (abort_k > 0 && abort_k <= nc + 1) begin
      e.is_abort = 1'b1;
      e.lat = abort_k;
      e.res = ref_shift(d, dr, abort_k - 1);
    end else begin
      e.is_abort = 1'b0;
      e.lat = nc + 1;
      e.res = ref_shift(d, dr, nc);
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) begin
      bus.start = 1'b0;
      bus.data_in = W'($urandom);
      bus.dir = 1'($urandom);
      bus.shift_cnt = CW'($urandom);
    end
    if (e.is_abort) begin
      repeat (abort_k - 1) begin
        @(posedge clk); #1;
      end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
    end else if (hold) begin
      // start stays high: ignored while busy, accepted again once IDLE
      repeat (nc + 2) @(posedge clk);
      #1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, n, nc, k, ld0;
    bus.start = 0; bus.dir = 0; bus.shift_cnt = '0; bus.data_in = '0; bus.abort = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_ld", 32'(bus.ld_sft_reg), 0);
    chk("rst_lr", 32'(bus.LR_sft_en), 0);
    chk("rst_data", 32'(bus.sft_reg_in), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_aborted", 32'(bus.aborted), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(9'h0A5, 1'b0, 3, 0, 0);
    issue(9'h1FF, 1'b1, 4, 0, 0);
    issue(9'h1FF, 1'b1, 12, 0, 0);
    issue(9'h133, 1'b0, 0, 0, 0);
    issue(9'h0B7, 1'b0, 6, 3, 0);
    issue(9'h0F0, 1'b1, 2, 0, 1);

    // start+abort together in IDLE must not be accepted
    wait_ready();
    ld0 = total_ld;
    bus.start = 1'b1; bus.abort = 1'b1; bus.data_in = 9'h155; bus.shift_cnt = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_abort_idle_ld", 32'(total_ld), 32'(ld0));
    chk("start_abort_idle_ready", 32'(bus.ready), 1);

    // Reset mid-SHIFT
    issue(9'h0C3, 1'b0, 6, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.ready), 1);
    chk("midrst_ld", 32'(bus.ld_sft_reg), 0);
    chk("midrst_lr", 32'(bus.LR_sft_en), 0);
    chk("midrst_data", 32'(bus.sft_reg_in), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_aborted", 32'(bus.aborted), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(bus.ready), 1);
    chk("postrst_lr", 32'(bus.LR_sft_en), 0);
    @(posedge clk); #1;

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      d  = int'($urandom_range(0, 511));
      n  = int'($urandom_range(0, 15));
      nc = (n > W) ? W : n;
      k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nc + 1)) : 0;
      issue(W'(d), 1'($urandom), n, k, ($urandom_range(0, 7) == 0) && (k == 0));
    end

    wait_ready();
    repeat (15) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("idle_at_end", 32'(active), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sft_reg_ctrl.md
# sft_reg_ctrl

Sequencing controller for the 9-bit `sft_register` datapath. It accepts a single shift command consisting of data, direction and shift count. For each command it drives one load cycle, then exactly N shift cycles, then reports completion with a one-cycle done pulse. It sits between the upstream command FSM and the shift register, and guarantees that load and shift are never requested in the same cycle.

## Interface
Parameters:
- `WIDTH`, default 9: data width; must match the shift register width.
- `CNT_W`, default 4: width of the shift-count input; must satisfy 2^CNT_W > WIDTH.

Ports:
- `sys_clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: command request; sampled only while `ready`=1.
- `dir`, in, 1: shift direction; 0 = left (`<<`), 1 = right (`>>`).
- `shift_cnt`, in, CNT_W: number of single-bit shifts N.
- `data_in`, in, WIDTH: value to load into the shift register.
- `abort`, in, 1: synchronous cancel of the current command.
- `ready`, out, 1: controller is in IDLE and can accept a command.
- `done`, out, 1: one-cycle pulse when a command completes.
- `aborted`, out, 1: one-cycle pulse when a command is cancelled.
- `ld_sft_reg`, out, 1: drives the register load enable.
- `LR_sft_en`, out, 2: drives the register shift control; 2'b10 = left, 2'b11 = right, 2'b00 = hold.
- `sft_reg_in`, out, WIDTH: drives the register parallel-load data.

## Operation
- The state machine has four states: IDLE, LOAD, SHIFT, DONE.
- `ready` is decoded from state (`ready` = state==IDLE). All other outputs are registered.
- IDLE:
  - Outputs `ld_sft_reg`=0, `LR_sft_en`=2'b00, `done`=0.
  - When `start`=1, the controller latches `dir`, `sft_reg_in`<=`data_in`, and the remaining count <= min(`shift_cnt`, WIDTH), then moves to LOAD.
- LOAD, one cycle:
  - `ld_sft_reg`=1 and `LR_sft_en`=2'b00. These must never overlap, because the register gives shift priority over load.
  - Next state is SHIFT if count>0, otherwise DONE.
- SHIFT:
  - `LR_sft_en`={1'b1, dir_latched} and `ld_sft_reg`=0.
  - Count decrements every cycle; the controller leaves for DONE on the cycle the count reaches 0.
  - Exactly N cycles are spent in SHIFT.
- DONE, one cycle:
  - `done`=1 and all datapath controls are 0.
  - Next state is IDLE.
- `sft_reg_in` holds its latched value from acceptance until the next acceptance.
- Clamping: a `shift_cnt` greater than WIDTH is clamped to WIDTH, so the register result is all zeros. This bounds latency.
- `start` while not `ready` is ignored; there is no queueing.
- `abort`=1 in LOAD, SHIFT or DONE:
  - Next state is IDLE.
  - `ld_sft_reg` and `LR_sft_en` go to 0 on the next edge.
  - `aborted` pulses for one cycle and `done` is not raised.
  - The register keeps whatever partial value it has.
- `abort`=1 in IDLE: no effect on state and no `aborted` pulse. If `start` is also high, abort wins and the command is dropped.
- Asynchronous reset while a command is running:
  - The controller returns to IDLE immediately.
  - All registered outputs clear and the count clears.
  - `ready`=1 once reset is released.

## Timing
- Reset values: `ld_sft_reg`=0, `LR_sft_en`=2'b00, `sft_reg_in`=0, `done`=0, `aborted`=0, state=IDLE, `ready`=1.
- Let E0 be the edge where `start` is accepted.
- After E0: `ld_sft_reg`=1 for exactly one cycle.
- At E1: the register loads `data_in`.
- Edges E2 through E(N+1): the register performs its N shifts.
- After E(N+1): `done`=1 for exactly one cycle.
- After E(N+2): `ready`=1.
- For N=0: `done` is high in the cycle after E1.
- Command-to-command throughput is N+3 cycles.
- `abort` sampled at edge Ek: `aborted` and IDLE are visible after Ek, and `ready`=1 in that same cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-SHIFT → all outputs reach their reset values immediately; after release `ready`=1 and `LR_sft_en`=2'b00.
- Left shift: `data_in`=9'h0A5, `dir`=0, `shift_cnt`=3 → one `ld_sft_reg` pulse, then `LR_sft_en`=2'b10 for 3 cycles, then `done` pulse. Register ends at 9'h128, and `done` occurs 4 edges after acceptance.
- Right shift with clamp: `data_in`=9'h1FF, `dir`=1, `shift_cnt`=4 → register ends at 9'h01F. Then a command with `shift_cnt`=12 → exactly 9 shift cycles and register result 9'h000.
- Zero count: `data_in`=9'h133, `shift_cnt`=0 → load pulse, then `done` the next cycle, no shift cycle. Register = 9'h133.
- Abort: `start` with `shift_cnt`=6, then `abort` during the 2nd SHIFT cycle → `aborted` pulses once and `done` is never raised. Register = data<<2, and the controller returns to `ready`=1.
- Protocol checks:
  - `start` held high throughout a command is ignored while busy and re-accepted in IDLE.
  - Same-cycle `start`+`abort` in IDLE → no acceptance.
  - An assertion checks that `ld_sft_reg` and `LR_sft_en[1]` are never both 1.
